// File: rtl/mem_write_monitor.sv
// Store-traffic checker for the single-cycle MIPS core. It compares committed
// stores, in order, against a loadable table of expected (address, data) pairs.
module mem_write_monitor #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int TIMEOUT = 1000,
    localparam int IDX_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int CNT_W  = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [ADDR_W-1:0] ign_lo,
    input  logic [ADDR_W-1:0] ign_hi,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [15:0]       ign_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    localparam int CYC_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CYC_W-1:0] CYC_SAT  = CYC_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_EXP - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] tbl_addr [NUM_EXP];
    logic [DATA_W-1:0] tbl_data [NUM_EXP];
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [CYC_W-1:0]  cyc, cyc_n;
    logic [CNT_W-1:0]  match_n;
    logic [15:0]       ign_n, ign_inc;
    logic [1:0]        code_n;
    logic [ADDR_W-1:0] faddr_n;
    logic [DATA_W-1:0] fdata_n;
    logic              in_window, hit, timed_out, restart;

    // An inverted window (ign_lo > ign_hi) can never satisfy both bounds, so it is empty.
    assign in_window = (dataadr >= ign_lo) && (dataadr <= ign_hi);
    assign hit       = (dataadr == tbl_addr[ptr]) && (writedata == tbl_data[ptr]);
    assign timed_out = (TIMEOUT != 0) && (cyc >= CYC_LAST);
    assign restart   = start && (state != S_RUN);
    assign ign_inc   = (ign_cnt == 16'hFFFF) ? ign_cnt : ign_cnt + 16'd1;

    assign busy = (state == S_RUN);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);
    assign done = pass || fail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (state == S_IDLE && exp_we && int'(exp_idx) < NUM_EXP) begin
            tbl_addr[exp_idx] <= exp_addr;
            tbl_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cyc       <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            fail_code <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cyc       <= cyc_n;
            match_cnt <= match_n;
            ign_cnt   <= ign_n;
            fail_code <= code_n;
            fail_addr <= faddr_n;
            fail_data <= fdata_n;
        end
    end

    // One event per edge; a write always outranks the timeout on the same cycle.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cyc_n   = cyc;
        match_n = match_cnt;
        ign_n   = ign_cnt;
        code_n  = fail_code;
        faddr_n = fail_addr;
        fdata_n = fail_data;

        case (state)
            S_RUN: begin
                if (cyc != CYC_SAT) begin
                    cyc_n = cyc + 1'b1;
                end
                if (memwrite && in_window) begin
                    ign_n = ign_inc;
                end else if (memwrite && hit) begin
                    match_n = match_cnt + 1'b1;
                    ptr_n   = ptr + 1'b1;
                    if (ptr == IDX_LAST) begin
                        state_n = S_PASS;
                    end
                end else if (memwrite) begin
                    state_n = S_FAIL;
                    code_n  = 2'd1;
                    faddr_n = dataadr;
                    fdata_n = writedata;
                end else if (timed_out) begin
                    state_n = S_FAIL;
                    code_n  = 2'd2;
                    faddr_n = '0;
                    fdata_n = '0;
                end
            end
            S_PASS: begin
                if (memwrite && in_window) begin
                    ign_n = ign_inc;
                end else if (memwrite) begin
                    state_n = S_FAIL;
                    code_n  = 2'd3;
                    faddr_n = dataadr;
                    fdata_n = writedata;
                end
            end
            default: begin
            end
        endcase

        // A start pulse from IDLE, PASS or FAIL wins over any write on the same edge.
        if (restart) begin
            state_n = S_RUN;
            ptr_n   = '0;
            cyc_n   = '0;
            match_n = '0;
            ign_n   = '0;
            code_n  = '0;
            faddr_n = '0;
            fdata_n = '0;
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Randomised and directed bench for mem_write_monitor; a behavioural model
// predicts the status after every edge and a separate monitor compares it.
module tb_mem_write_monitor;

    localparam int NUM_EXP = 4;
    localparam int TIMEOUT = 24;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [31:0] faddr;
        logic [31:0] fdata;
        logic [2:0]  match;
        logic [15:0] ign;
    } status_t;

    typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;

    logic        clk = 0;
    logic        reset, start, memwrite, exp_we;
    logic [31:0] dataadr, writedata, exp_addr, exp_data, ign_lo, ign_hi;
    logic [1:0]  exp_idx;
    logic        busy, done, pass, fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_addr, fail_data;
    logic [2:0]  match_cnt;
    logic [15:0] ign_cnt;

    int checks = 0;
    int errors = 0;
    status_t expq[$];

    mstate_t     ms;
    int          mmatch, mign, mcode, mcyc;
    logic [31:0] mfa, mfd;
    logic [31:0] mt_addr [NUM_EXP];
    logic [31:0] mt_data [NUM_EXP];

    mem_write_monitor #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(NUM_EXP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .exp_we(exp_we),
        .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .ign_lo(ign_lo), .ign_hi(ign_hi), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .match_cnt(match_cnt), .ign_cnt(ign_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input status_t exp, input string name);
        status_t act;
        act = '{busy, done, pass, fail, fail_code, fail_addr, fail_data, match_cnt, ign_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got b%0b d%0b p%0b f%0b code%0d a%0h d%0h m%0d i%0d want b%0b d%0b p%0b f%0b code%0d a%0h d%0h m%0d i%0d",
                     name, $time, act.busy, act.done, act.pass, act.fail, act.code, act.faddr,
                     act.fdata, act.match, act.ign, exp.busy, exp.done, exp.pass, exp.fail,
                     exp.code, exp.faddr, exp.fdata, exp.match, exp.ign);
        end
    endtask

    // Reference behaviour, evaluated with the inputs seen at a rising edge.
    task automatic modelStep();
        logic win;
        win = (dataadr >= ign_lo) && (dataadr <= ign_hi);
        if (!reset) begin
            ms = M_IDLE; mmatch = 0; mign = 0; mcode = 0; mcyc = 0; mfa = 0; mfd = 0;
            for (int i = 0; i < NUM_EXP; i++) begin
                mt_addr[i] = 0;
                mt_data[i] = 0;
            end
            return;
        end
        if (ms == M_IDLE && exp_we) begin
            mt_addr[exp_idx] = exp_addr;
            mt_data[exp_idx] = exp_data;
        end
        if (start && ms != M_RUN) begin
            ms = M_RUN; mmatch = 0; mign = 0; mcode = 0; mcyc = 0; mfa = 0; mfd = 0;
            return;
        end
        if (ms == M_RUN) begin
            if (memwrite && win) begin
                if (mign < 65535) mign++;
            end else if (memwrite && dataadr == mt_addr[mmatch] && writedata == mt_data[mmatch]) begin
                mmatch++;
                if (mmatch == NUM_EXP) ms = M_PASS;
            end else if (memwrite) begin
                ms = M_FAIL; mcode = 1; mfa = dataadr; mfd = writedata;
            end else if (mcyc >= TIMEOUT - 1) begin
                ms = M_FAIL; mcode = 2; mfa = 0; mfd = 0;
            end
            mcyc++;
        end else if (ms == M_PASS && memwrite) begin
            if (win) begin
                if (mign < 65535) mign++;
            end else begin
                ms = M_FAIL; mcode = 3; mfa = dataadr; mfd = writedata;
            end
        end
    endtask

    function automatic status_t modelStatus();
        status_t s;
        s.busy  = (ms == M_RUN);
        s.done  = (ms == M_PASS) || (ms == M_FAIL);
        s.pass  = (ms == M_PASS);
        s.fail  = (ms == M_FAIL);
        s.code  = 2'(mcode);
        s.faddr = mfa;
        s.fdata = mfd;
        s.match = 3'(mmatch);
        s.ign   = 16'(mign);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        expq.push_back(modelStatus());
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic mw, input logic [31:0] a, input logic [31:0] d);
        start = st; memwrite = mw; dataadr = a; writedata = d;
        tick();
        start = 0; memwrite = 0; exp_we = 0;
    endtask

    task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
        applyStimulus(0, 0, 0, 0);
    endtask

    task automatic doReset();
        reset = 0;
        #1;
        checkOutput('0, "async_reset");
        tick();
        reset = 1;
    endtask

    task automatic loadPlanTable();
        loadEntry(0, 0, 1); loadEntry(1, 4, 2); loadEntry(2, 8, 3); loadEntry(3, 12, 4);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) checkOutput(expq.pop_front(), "cycle");
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        reset = 1; start = 0; memwrite = 0; dataadr = 0; writedata = 0;
        exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0; ign_lo = 80; ign_hi = 80;
        @(negedge clk); #1;
        doReset();
        loadPlanTable();

        // Out-of-order store, then the correct order with scratch traffic mixed in.
        applyStimulus(1, 0, 0, 0); applyStimulus(0, 1, 4, 2);
        checkOutput('{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd4, 32'd2, 3'd0, 16'd0}, "plan_order_fail");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 80, 5); applyStimulus(0, 1, 0, 1); applyStimulus(0, 1, 80, 12);
        applyStimulus(0, 1, 4, 2); applyStimulus(0, 1, 8, 3); applyStimulus(0, 1, 12, 4);
        checkOutput('{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 3'd4, 16'd2}, "plan_pass");
        applyStimulus(0, 1, 80, 9);
        checkOutput('{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 3'd4, 16'd3}, "plan_pass_ignored");
        applyStimulus(0, 1, 100, 9);
        checkOutput('{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'd100, 32'd9, 3'd4, 16'd3}, "plan_extra_write");

        applyStimulus(1, 0, 0, 0); applyStimulus(0, 1, 88, 7);
        checkOutput('{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd88, 32'd7, 3'd0, 16'd0}, "plan_mismatch");

        // Timeout lands exactly TIMEOUT edges after the start edge.
        applyStimulus(1, 0, 0, 0);
        repeat (TIMEOUT - 1) applyStimulus(0, 0, 0, 0);
        checkOutput('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 16'd0}, "plan_before_timeout");
        applyStimulus(0, 0, 0, 0);
        checkOutput('{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0, 32'd0, 3'd0, 16'd0}, "plan_timeout");

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1); applyStimulus(0, 1, 4, 2); applyStimulus(0, 1, 8, 3);
        repeat (TIMEOUT - 4) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 12, 4);
        checkOutput('{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 3'd4, 16'd0}, "plan_last_cycle_pass");

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1); applyStimulus(0, 1, 4, 2); applyStimulus(0, 1, 8, 3);
        doReset();
        loadPlanTable();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1); applyStimulus(0, 1, 4, 2); applyStimulus(0, 1, 8, 3);
        applyStimulus(0, 1, 12, 4);
        checkOutput('{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 3'd4, 16'd0}, "plan_after_reset");

        for (int t = 0; t < 30; t++) begin
            doReset();
            for (int i = 0; i < NUM_EXP; i++) loadEntry(i, 4 * $urandom_range(0, 15), $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                ign_lo = 200; ign_hi = 100;
            end else begin
                ign_lo = $urandom_range(60, 80);
                ign_hi = ign_lo + $urandom_range(0, 8);
            end
            applyStimulus(1, 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                r = $urandom_range(0, 99);
                if ($urandom_range(0, 9) == 0) begin
                    exp_we = 1; exp_idx = 2'($urandom_range(0, 3)); exp_addr = $urandom; exp_data = $urandom;
                end
                if (t % 10 == 3 && c == 5) begin
                    doReset();
                end else if (r < 45 && ms == M_RUN) begin
                    applyStimulus(0, 1, mt_addr[mmatch], mt_data[mmatch]);
                end else if (r < 60 && ign_lo <= ign_hi) begin
                    applyStimulus(0, 1, $urandom_range(ign_lo, ign_hi), $urandom);
                end else if (r < 68) begin
                    applyStimulus(0, 1, $urandom_range(0, 127), $urandom_range(0, 7));
                end else if (r < 72 && ms == M_RUN) begin
                    a = mt_data[mmatch] ^ 32'd1;
                    applyStimulus(0, 1, mt_addr[mmatch], a);
                end else begin
                    applyStimulus($urandom_range(0, 24) == 0, 0, 0, 0);
                end
            end
        end

        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
